// File: rtl/kyber_pwm2_core_if.sv
// Bank/handshake bundle for kyber_pwm2_core; acc and old-c read ports exist only with KYBER_PWM2_ACC_EN.
interface kyber_pwm2_core_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [6:0]  raddr;
  logic [11:0] a_br1_rdata;
  logic [11:0] a_br2_rdata;
  logic [11:0] b_br1_rdata;
  logic [11:0] b_br2_rdata;
  logic [5:0]  zeta_addr;
  logic [11:0] zeta_rdata;
  logic        we;
  logic [6:0]  waddr;
  logic [11:0] c_br1_wdata;
  logic [11:0] c_br2_wdata;
`ifdef KYBER_PWM2_ACC_EN
  logic        acc;
  logic [11:0] c_br1_rdata;
  logic [11:0] c_br2_rdata;

  modport master (
    input  start, a_br1_rdata, a_br2_rdata, b_br1_rdata, b_br2_rdata, zeta_rdata,
    input  acc, c_br1_rdata, c_br2_rdata,
    output busy, done, raddr, zeta_addr, we, waddr, c_br1_wdata, c_br2_wdata
  );
  modport slave (
    output start, a_br1_rdata, a_br2_rdata, b_br1_rdata, b_br2_rdata, zeta_rdata,
    output acc, c_br1_rdata, c_br2_rdata,
    input  busy, done, raddr, zeta_addr, we, waddr, c_br1_wdata, c_br2_wdata
  );
`else
  modport master (
    input  start, a_br1_rdata, a_br2_rdata, b_br1_rdata, b_br2_rdata, zeta_rdata,
    output busy, done, raddr, zeta_addr, we, waddr, c_br1_wdata, c_br2_wdata
  );
  modport slave (
    output start, a_br1_rdata, a_br2_rdata, b_br1_rdata, b_br2_rdata, zeta_rdata,
    input  busy, done, raddr, zeta_addr, we, waddr, c_br1_wdata, c_br2_wdata
  );
`endif
endinterface

// File: rtl/kyber_pwm2_core.sv
// Kyber PWM2 base-multiplication engine over 0,2,1,3-ordered coefficient banks.
// Define KYBER_PWM2_ACC_EN to add accumulate mode (c = old c + product mod Q).
module kyber_pwm2_core #(
  parameter int unsigned Q    = 3329,
  parameter int unsigned LOGN = 8
) (
  input logic               clk,
  input logic               reset,
  kyber_pwm2_core_if.master bus
);
  localparam logic [7:0]  LAST_RD   = 8'(2 ** (LOGN - 1));
  localparam logic [7:0]  FIRST_WR  = 8'd8;
  localparam logic [7:0]  LAST_WR   = 8'(2 ** (LOGN - 1) + 7);
  localparam logic [41:0] BARRETT_M = 42'((64'd1 << 26) / 64'(Q));
  localparam logic [11:0] QV        = 12'(Q);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       we_d;
  logic       we_q;
  logic [6:0] waddr_q;
  logic [6:0] raddr;

  // x < 2^26: floor estimate is at most 2 below the true quotient
  function automatic logic [11:0] mod_q(input logic [25:0] x);
    logic [41:0] prod;
    logic [15:0] qt;
    logic [27:0] r;
    prod = 42'(x) * BARRETT_M;
    qt   = 16'(prod >> 26);
    r    = 28'(x) - 28'(qt) * 28'(Q);
    if (r >= 28'(Q)) r = r - 28'(Q);
    if (r >= 28'(Q)) r = r - 28'(Q);
    return r[11:0];
  endfunction

  function automatic logic [11:0] add_q(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = 13'(a) + 13'(b);
    if (s >= 13'(Q)) s = s - 13'(Q);
    return s[11:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_RUN;
        cnt_d   = 8'd1;
      end
      S_RUN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_RD) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_WR) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    we_d = ((state_d == S_RUN) || (state_d == S_DRAIN)) && (cnt_d >= FIRST_WR);
  end

  always_comb begin
    raddr = '0;
    if (state_q == S_RUN) raddr = 7'(cnt_q - 8'd1);
    bus.raddr     = raddr;
    bus.zeta_addr = raddr[6:1];
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
  end

  // Lane 0 = BR1 (gamma), lane 1 = BR2 (-gamma). Every stage register is live for
  // exactly one cycle per iteration; the write stage picks c0 or c1 by cycle parity.
  logic [11:0] a_in [2], b_in [2], acc_term [2];
  logic [11:0] a0_q [2], b0_q [2], g_q [2], g2_q [2], t_q [2];
  logic [11:0] c1r_q [2], c1r2_q [2], c0_q [2], c1_q [2], c1h_q [2], wd_q [2];
  logic [23:0] p11_q [2], p00_q [2], p00b_q [2];
  logic [24:0] x_q [2], m_q [2];

`ifdef KYBER_PWM2_ACC_EN
  logic        acc_q;
  logic [11:0] c_in [2];
  logic [11:0] oc_q [2][5];

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 2; l++) begin
      oc_q[l][0] <= c_in[l];
      for (int unsigned s = 1; s < 5; s++) oc_q[l][s] <= oc_q[l][s-1];
    end
    if (reset) acc_q <= 1'b0;
    else if (state_q == S_IDLE && bus.start) acc_q <= bus.acc;
  end
`endif

  always_comb begin
    a_in[0] = bus.a_br1_rdata;
    a_in[1] = bus.a_br2_rdata;
    b_in[0] = bus.b_br1_rdata;
    b_in[1] = bus.b_br2_rdata;
`ifdef KYBER_PWM2_ACC_EN
    c_in[0] = bus.c_br1_rdata;
    c_in[1] = bus.c_br2_rdata;
    for (int unsigned l = 0; l < 2; l++) acc_term[l] = acc_q ? oc_q[l][4] : '0;
`else
    acc_term[0] = '0;
    acc_term[1] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 2; l++) begin
      a0_q[l]   <= a_in[l];
      b0_q[l]   <= b_in[l];
      p11_q[l]  <= 24'(a_in[l]) * 24'(b_in[l]);
      p00_q[l]  <= 24'(a0_q[l]) * 24'(b0_q[l]);
      x_q[l]    <= 25'(24'(a0_q[l]) * 24'(b_in[l])) + 25'(24'(a_in[l]) * 24'(b0_q[l]));
      g_q[l]    <= (l == 0) ? bus.zeta_rdata : QV - bus.zeta_rdata;
      t_q[l]    <= mod_q(26'(p11_q[l]));
      c1r_q[l]  <= mod_q(26'(x_q[l]));
      p00b_q[l] <= p00_q[l];
      g2_q[l]   <= g_q[l];
      m_q[l]    <= 25'(24'(t_q[l]) * 24'(g2_q[l])) + 25'(p00b_q[l]);
      c1r2_q[l] <= c1r_q[l];
      c0_q[l]   <= mod_q(26'(m_q[l]));
      c1_q[l]   <= c1r2_q[l];
      c1h_q[l]  <= c1_q[l];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wd_q[0] <= '0;
      wd_q[1] <= '0;
    end else begin
      we_q <= we_d;
      if (we_d) begin
        waddr_q <= 7'(cnt_d - FIRST_WR);
        for (int unsigned l = 0; l < 2; l++)
          wd_q[l] <= add_q(cnt_d[0] ? c1h_q[l] : c0_q[l], acc_term[l]);
      end
    end
  end

  assign bus.we          = we_q;
  assign bus.waddr       = waddr_q;
  assign bus.c_br1_wdata = wd_q[0];
  assign bus.c_br2_wdata = wd_q[1];
endmodule

// File: tb/tb_kyber_pwm2_core.sv
// Directed bench for kyber_pwm2_core: timing, fixed vectors, Kyber-gamma golden model, abort.
`timescale 1ns/1ps
module tb_kyber_pwm2_core;
  localparam int Q = 3329;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kyber_pwm2_core_if bus();
  kyber_pwm2_core #(.Q(3329), .LOGN(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [11:0] am1 [128], am2 [128], bm1 [128], bm2 [128], cm1 [128], cm2 [128];
  logic [11:0] rom [64];
  logic        fill_req = 1'b0;
  logic [11:0] fill_v;
  int pa [256], pb [256], pc [256];
  int total = 0;
  int bad = 0;

  // Synchronous bank / ROM model: one-cycle read latency, writes on we.
  always @(posedge clk) begin
    bus.a_br1_rdata <= am1[bus.raddr];
    bus.a_br2_rdata <= am2[bus.raddr];
    bus.b_br1_rdata <= bm1[bus.raddr];
    bus.b_br2_rdata <= bm2[bus.raddr];
    bus.zeta_rdata  <= rom[bus.zeta_addr];
`ifdef KYBER_PWM2_ACC_EN
    bus.c_br1_rdata <= cm1[bus.raddr];
    bus.c_br2_rdata <= cm2[bus.raddr];
`endif
    if (fill_req) begin
      for (int i = 0; i < 128; i++) begin cm1[i] = fill_v; cm2[i] = fill_v; end
    end else if (bus.we === 1'b1) begin
      cm1[bus.waddr] = bus.c_br1_wdata;
      cm2[bus.waddr] = bus.c_br2_wdata;
    end
  end

  function automatic int brv6(int k);
    int r = 0;
    for (int i = 0; i < 6; i++) if (((k >> i) & 1) != 0) r |= 1 << (5 - i);
    return r;
  endfunction

  function automatic int gamma_k(int k);
    longint r = 1;
    for (int i = 0; i < 2 * brv6(k) + 1; i++) r = (r * 17) % Q;
    return int'(r);
  endfunction

  task automatic fill_c(input logic [11:0] v);
    @(negedge clk); fill_v = v; fill_req = 1'b1;
    @(negedge clk); fill_req = 1'b0;
  endtask

  task automatic load_rom_kyber();
    for (int k = 0; k < 64; k++) rom[k] = 12'(gamma_k(k));
  endtask

  // Scatter 256-coefficient polys into the 0,2,1,3 bank layout.
  task automatic load_polys();
    for (int i = 0; i < 256; i++) begin
      int idx;
      idx = 2 * (i >> 2) + (i & 1);
      if ((i & 2) == 0) begin am1[idx] = 12'(pa[i]); bm1[idx] = 12'(pb[i]); end
      else begin am2[idx] = 12'(pa[i]); bm2[idx] = 12'(pb[i]); end
    end
  endtask

  function automatic int out_coef(int i);
    int idx;
    idx = 2 * (i >> 2) + (i & 1);
    return ((i & 2) == 0) ? int'(cm1[idx]) : int'(cm2[idx]);
  endfunction

  task automatic run_pass(input bit acc_v, input bit start_at_done,
                          output int done_cyc, output int we_cnt, output int first_we,
                          output bit order_ok, output bit busy_ok);
    int n;
    done_cyc = -1; we_cnt = 0; first_we = -1; order_ok = 1'b1; busy_ok = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
`ifdef KYBER_PWM2_ACC_EN
    bus.acc = acc_v;
`else
    if (acc_v) $display("note: acc requested without accumulate build");
`endif
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (n <= 300) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.we === 1'b1) begin
        we_cnt++;
        if (first_we < 0) first_we = n;
        if (int'(bus.waddr) != n - 8) order_ok = 1'b0;
      end
      if (bus.done === 1'b1) begin done_cyc = n; break; end
      @(negedge clk);
      n++;
    end
    if (start_at_done && done_cyc > 0) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [74:0] v;
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    v = {bus.busy, bus.done, bus.we, bus.raddr, bus.waddr, bus.zeta_addr,
         bus.c_br1_wdata, bus.c_br2_wdata, 24'd0};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", v); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_unit();
    int dc, wc, fw; bit ok, bz;
    for (int i = 0; i < 256; i++) begin pa[i] = (i % 2 == 0) ? 1 : 0; pb[i] = pa[i]; end
    load_polys();
    load_rom_kyber();
    fill_c(12'hFFF);
    run_pass(1'b0, 1'b0, dc, wc, fw, ok, bz);
    total++; if (dc != 136) begin bad++; $display("FAIL unit_done_cycle got=%0d want=136", dc); end
    total++; if (wc != 128) begin bad++; $display("FAIL unit_we_count got=%0d want=128", wc); end
    total++; if (fw != 8) begin bad++; $display("FAIL unit_first_we got=%0d want=8", fw); end
    total++; if (!ok) begin bad++; $display("FAIL unit_waddr_order got=0 want=1"); end
    total++; if (!bz) begin bad++; $display("FAIL unit_busy got=0 want=1"); end
    for (int j = 0; j < 128; j++) begin
      logic [11:0] e;
      e = (j % 2 == 0) ? 12'd1 : 12'd0;
      total++; if (cm1[j] !== e) begin bad++; $display("FAIL unit_br1[%0d] got=%0d want=%0d", j, cm1[j], e); end
      total++; if (cm2[j] !== e) begin bad++; $display("FAIL unit_br2[%0d] got=%0d want=%0d", j, cm2[j], e); end
    end
  endtask

  task automatic test_pair0();
    int dc, wc, fw; bit ok, bz;
    for (int i = 0; i < 256; i++) begin pa[i] = 0; pb[i] = 0; end
    pa[1] = 1; pb[1] = 1; pa[3] = 1; pb[3] = 1;
    load_polys();
    load_rom_kyber();
    run_pass(1'b0, 1'b0, dc, wc, fw, ok, bz);
    total++; if (cm1[0] !== 12'd17) begin bad++; $display("FAIL pair0_br1_c0 got=%0d want=17", cm1[0]); end
    total++; if (cm2[0] !== 12'd3312) begin bad++; $display("FAIL pair0_br2_c0 got=%0d want=3312", cm2[0]); end
    total++; if (cm1[1] !== 12'd0) begin bad++; $display("FAIL pair0_br1_c1 got=%0d want=0", cm1[1]); end
    total++; if (cm2[1] !== 12'd0) begin bad++; $display("FAIL pair0_br2_c1 got=%0d want=0", cm2[1]); end
  endtask

  task automatic test_boundary();
    int dc, wc, fw; bit ok, bz;
    for (int i = 0; i < 256; i++) begin pa[i] = 3328; pb[i] = 3328; end
    load_polys();
    for (int k = 0; k < 64; k++) rom[k] = 12'd17;
    run_pass(1'b0, 1'b0, dc, wc, fw, ok, bz);
    for (int j = 0; j < 128; j++) begin
      logic [11:0] e1, e2;
      e1 = (j % 2 == 0) ? 12'd18 : 12'd2;
      e2 = (j % 2 == 0) ? 12'd3313 : 12'd2;
      total++; if (cm1[j] !== e1) begin bad++; $display("FAIL bound_br1[%0d] got=%0d want=%0d", j, cm1[j], e1); end
      total++; if (cm2[j] !== e2) begin bad++; $display("FAIL bound_br2[%0d] got=%0d want=%0d", j, cm2[j], e2); end
    end
  endtask

  task automatic test_random();
    int dc, wc, fw; bit ok, bz;
    for (int i = 0; i < 256; i++) begin
      pa[i] = int'($urandom_range(0, Q - 1));
      pb[i] = int'($urandom_range(0, Q - 1));
    end
    for (int p = 0; p < 128; p++) begin
      longint a0, a1, b0, b1, g;
      a0 = pa[2*p]; a1 = pa[2*p+1]; b0 = pb[2*p]; b1 = pb[2*p+1];
      g = (p % 2 == 0) ? gamma_k(p / 2) : Q - gamma_k(p / 2);
      pc[2*p]   = int'((a0 * b0 + ((a1 * b1) % Q) * g) % Q);
      pc[2*p+1] = int'((a0 * b1 + a1 * b0) % Q);
    end
    load_polys();
    load_rom_kyber();
    run_pass(1'b0, 1'b0, dc, wc, fw, ok, bz);
    total++; if (dc != 136) begin bad++; $display("FAIL rand_done_cycle got=%0d want=136", dc); end
    for (int i = 0; i < 256; i++) begin
      total++;
      if (out_coef(i) != pc[i]) begin bad++; $display("FAIL rand_coef[%0d] got=%0d want=%0d", i, out_coef(i), pc[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int dc, wc, fw; bit ok, bz;
    run_pass(1'b0, 1'b1, dc, wc, fw, ok, bz);
    total++; if (dc != 136) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=136", dc); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_at_done_busy got=%b want=0", bus.busy); end
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_at_done_idle got=%b want=0", bus.busy); end
  endtask

  task automatic test_abort();
    int dc, wc, fw; bit ok, bz, saw_done;
    for (int i = 0; i < 256; i++) begin pa[i] = (i % 2 == 0) ? 1 : 0; pb[i] = pa[i]; end
    load_polys();
    load_rom_kyber();
    fill_c(12'hFFF);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int n = 1; n <= 71; n++) begin
      if (n == 50) bus.start = 1'b1;
      if (n == 51) bus.start = 1'b0;
      if (n == 60) begin
        total++; if (bus.raddr !== 7'd59) begin bad++; $display("FAIL restart_ignored_raddr got=%0d want=59", bus.raddr); end
      end
      if (n == 70) reset = 1'b1;
      if (n == 71) begin
        total++; if (bus.we !== 1'b0) begin bad++; $display("FAIL abort_we got=%b want=0", bus.we); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
        reset = 1'b0;
      end
      if (n < 71) @(negedge clk);
    end
    saw_done = 1'b0;
    repeat (150) begin @(negedge clk); if (bus.done === 1'b1) saw_done = 1'b1; end
    total++; if (saw_done) begin bad++; $display("FAIL abort_no_done got=1 want=0"); end
    total++; if (cm1[62] !== 12'd1) begin bad++; $display("FAIL abort_last_write got=%0d want=1", cm1[62]); end
    total++; if (cm1[63] !== 12'hFFF) begin bad++; $display("FAIL abort_unwritten got=%0d want=4095", cm1[63]); end
    run_pass(1'b0, 1'b0, dc, wc, fw, ok, bz);
    total++; if (dc != 136) begin bad++; $display("FAIL after_abort_done got=%0d want=136", dc); end
    total++; if (wc != 128) begin bad++; $display("FAIL after_abort_we got=%0d want=128", wc); end
    total++; if (cm1[63] !== 12'd0) begin bad++; $display("FAIL after_abort_c1 got=%0d want=0", cm1[63]); end
  endtask

`ifdef KYBER_PWM2_ACC_EN
  task automatic test_acc();
    int dc, wc, fw; bit ok, bz;
    for (int i = 0; i < 256; i++) begin pa[i] = (i % 2 == 0) ? 1 : 0; pb[i] = pa[i]; end
    load_polys();
    fill_c(12'd3328);
    run_pass(1'b1, 1'b0, dc, wc, fw, ok, bz);
    total++; if (dc != 136) begin bad++; $display("FAIL acc_done got=%0d want=136", dc); end
    for (int j = 0; j < 128; j++) begin
      logic [11:0] e;
      e = (j % 2 == 0) ? 12'd0 : 12'd3328;
      total++; if (cm1[j] !== e) begin bad++; $display("FAIL acc_br1[%0d] got=%0d want=%0d", j, cm1[j], e); end
      total++; if (cm2[j] !== e) begin bad++; $display("FAIL acc_br2[%0d] got=%0d want=%0d", j, cm2[j], e); end
    end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
`ifdef KYBER_PWM2_ACC_EN
    bus.acc = 1'b0;
`endif
    reset = 1'b1;
    test_reset();
    test_unit();
    test_pair0();
    test_boundary();
    test_random();
    test_back_to_back();
    test_abort();
`ifdef KYBER_PWM2_ACC_EN
    test_acc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
